// File: rtl/scramble_pkg.sv
// Shared types and constants for the toggle-grid scramble sequencer.
package scramble_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    SETUP = 3'd2,
    FIRE  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Previous-move marker that no 3-bit candidate can ever match.
  localparam logic [3:0] MOVE_NONE = 4'hF;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One-hot line enable for a 2-bit row/column index.
  function automatic logic [3:0] move_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; seed must be nonzero so the state never locks at zero.
module lfsr16
  import scramble_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift right, folding the feedback polynomial in when a one drops out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  // Advance every cycle so the scramble seed depends on when the user presses start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/scramble_sequencer.sv
// Move controller for the 4x4 toggle-cell grid: user pass-through or LFSR scramble.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | user owns the grid; selection and fire passed through, 1-cycle delay
// PICK  | draw lfsr[2:0] as a candidate; retry while it repeats the last move
// SETUP | enables driven for the chosen move, fire held low
// FIRE  | same enables, fire high for one cycle; move count decremented
// GAP   | enables off for GAP_CYCLES cycles before the next pick
// DONE  | one-cycle scramble_done pulse, then back to IDLE
module scramble_sequencer
  import scramble_pkg::*;
#(
  parameter int unsigned NUM_MOVES  = 16,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] user_row_column,
  input  logic       user_nRow,
  input  logic       user_error,
  input  logic       user_fire,
  input  logic       scramble_start,
  input  logic       abort,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       fire,
  output logic       busy,
  output logic       scramble_done,
  output logic [7:0] moves_left
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e           state_q;
  logic [3:0]       row_q;
  logic [3:0]       col_q;
  logic             fire_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       moves_left_q;
  logic [3:0]       prev_move_q;
  logic [GAP_W-1:0] gap_cnt_q;

  logic [15:0] lfsr_val;
  logic        lfsr_unused;
  logic [3:0]  cand_move;
  logic [3:0]  cand_row;
  logic [3:0]  cand_col;
  logic [3:0]  user_row_d;
  logic [3:0]  user_col_d;
  logic        user_fire_d;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr_val)
  );

  // Only the low three bits pick moves; the rest just carry the sequence.
  assign lfsr_unused = ^lfsr_val[15:3];

  // Candidate move: bit2 selects column (1) or row (0), bits1:0 the line index.
  assign cand_move = {1'b0, lfsr_val[2:0]};
  assign cand_row  = lfsr_val[2] ? 4'b0000 : move_onehot(lfsr_val[1:0]);
  assign cand_col  = lfsr_val[2] ? move_onehot(lfsr_val[1:0]) : 4'b0000;

  // User selection as it would appear on the enables in IDLE.
  always_comb begin
    user_row_d = 4'b0000;
    user_col_d = 4'b0000;
    if (!user_error) begin
      if (!user_nRow) begin
        user_row_d = user_row_column;
      end else begin
        user_col_d = user_row_column;
      end
    end
  end

  // A user fire only reaches the cells with a valid, nonempty selection.
  assign user_fire_d = user_fire & ~user_error & (|user_row_column);

  // Sequencer FSM; every output is a register written here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      row_q        <= 4'b0000;
      col_q        <= 4'b0000;
      fire_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      moves_left_q <= 8'd0;
      prev_move_q  <= MOVE_NONE;
      gap_cnt_q    <= '0;
    end else begin
      fire_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q != IDLE && abort) begin
        // Abort from any busy state; a fire already registered in FIRE has gone out.
        state_q      <= IDLE;
        row_q        <= 4'b0000;
        col_q        <= 4'b0000;
        busy_q       <= 1'b0;
        moves_left_q <= 8'd0;
        prev_move_q  <= MOVE_NONE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (scramble_start) begin
              state_q      <= PICK;
              busy_q       <= 1'b1;
              moves_left_q <= 8'(NUM_MOVES);
              row_q        <= 4'b0000;
              col_q        <= 4'b0000;
            end else begin
              row_q  <= user_row_d;
              col_q  <= user_col_d;
              fire_q <= user_fire_d;
            end
          end
          PICK: begin
            if (cand_move != prev_move_q) begin
              prev_move_q <= cand_move;
              row_q       <= cand_row;
              col_q       <= cand_col;
              state_q     <= SETUP;
            end
          end
          SETUP: begin
            fire_q  <= 1'b1;
            state_q <= FIRE;
          end
          FIRE: begin
            row_q     <= 4'b0000;
            col_q     <= 4'b0000;
            gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
            if (moves_left_q != 8'd0) begin
              moves_left_q <= moves_left_q - 8'd1;
            end
            state_q <= GAP;
          end
          GAP: begin
            if (gap_cnt_q == '0) begin
              if (moves_left_q == 8'd0) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                state_q <= PICK;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q - 1'b1;
            end
          end
          DONE: begin
            busy_q      <= 1'b0;
            prev_move_q <= MOVE_NONE;
            state_q     <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            row_q   <= 4'b0000;
            col_q   <= 4'b0000;
          end
        endcase
      end
    end
  end

  assign row           = row_q;
  assign col           = col_q;
  assign fire          = fire_q;
  assign busy          = busy_q;
  assign scramble_done = done_q;
  assign moves_left    = moves_left_q;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Directed and randomized checks of the scramble sequencer against a move-level model.
`timescale 1ns/1ps
module tb_scramble_sequencer;
  import scramble_pkg::*;

  localparam int N = 16;
  localparam int G = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int JMAX = 600;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] user_row_column = 4'b0;
  logic       user_nRow = 1'b0;
  logic       user_error = 1'b0;
  logic       user_fire = 1'b0;
  logic       scramble_start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       fire;
  logic       busy;
  logic       scramble_done;
  logic [7:0] moves_left;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_lfsr = SEED;

  always #5 clk = ~clk;

  scramble_sequencer #(
    .NUM_MOVES (N),
    .GAP_CYCLES(G),
    .LFSR_SEED (SEED)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .user_row_column(user_row_column),
    .user_nRow      (user_nRow),
    .user_error     (user_error),
    .user_fire      (user_fire),
    .scramble_start (scramble_start),
    .abort          (abort),
    .row            (row),
    .col            (col),
    .fire           (fire),
    .busy           (busy),
    .scramble_done  (scramble_done),
    .moves_left     (moves_left)
  );

  // Multiply by x^-1 modulo x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int onehot_idx(input logic [3:0] s);
    int k;
    k = 0;
    for (int b = 0; b < 4; b++) if (s[b]) k = b;
    return k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_lfsr = lfsr_next(m_lfsr);
    #1;
  endtask

  initial begin
    logic [15:0] hist [JMAX];
    int          fire_cyc[$];
    int          fire_mv[$];
    logic [7:0]  last_en;
    int          done_cyc;
    int          inj;
    int          p, c;
    logic [3:0]  prev;
    int          nf;
    bit          hit;
    bit          bad_evt;
    logic [3:0]  rc;
    logic        nr, er, uf;

    // Reset state
    #12;
    check("rst_row", row, 0);
    check("rst_col", col, 0);
    check("rst_fire", fire, 0);
    check("rst_busy", busy, 0);
    check("rst_done", scramble_done, 0);
    check("rst_moves", moves_left, 0);
    check("rst_lfsr", dut.u_lfsr.out, SEED);
    tick();
    reset = 1'b1;
    tick();
    check("lfsr_track", dut.u_lfsr.out, m_lfsr);

    // User row move
    user_nRow = 1'b0; user_row_column = 4'b0100; user_fire = 1'b1;
    tick();
    user_fire = 1'b0;
    check("user_row", row, 4'b0100);
    check("user_col", col, 0);
    check("user_fire", fire, 1);
    check("user_busy", busy, 0);
    tick();
    check("user_fire_1cyc", fire, 0);

    // Errored selection
    user_error = 1'b1; user_fire = 1'b1;
    tick();
    user_fire = 1'b0;
    check("err_row", row, 0);
    check("err_col", col, 0);
    check("err_fire", fire, 0);
    user_error = 1'b0;

    // Random pass-through patterns
    for (int i = 0; i < 20; i++) begin
      rc = 4'($urandom_range(0, 15));
      nr = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 3) == 0);
      uf = 1'($urandom_range(0, 1));
      user_row_column = rc; user_nRow = nr; user_error = er; user_fire = uf;
      tick();
      check("rnd_row", row, er ? 4'b0 : (nr ? 4'b0 : rc));
      check("rnd_col", col, er ? 4'b0 : (nr ? rc : 4'b0));
      check("rnd_fire", fire, uf && !er && (rc != 0));
    end
    user_fire = 1'b0; user_error = 1'b0;

    // Full scramble with user fires injected
    scramble_start = 1'b1;
    tick();
    scramble_start = 1'b0;
    hist[0] = m_lfsr;
    check("scr_busy", busy, 1);
    check("scr_moves", moves_left, N);
    done_cyc = -1;
    inj = 0;
    last_en = {row, col};
    for (int j = 1; j < JMAX; j++) begin
      if (inj < 10 && (j % 11) == 5) begin
        user_row_column = 4'b0001 << $urandom_range(0, 3);
        user_nRow = 1'($urandom_range(0, 1));
        user_fire = 1'b1;
        inj++;
      end
      tick();
      user_fire = 1'b0;
      hist[j] = m_lfsr;
      if ($countones({row, col}) > 1) check("scr_excl", {row, col}, 0);
      if (fire) begin
        check("scr_onehot", $countones({row, col}), 1);
        check("scr_stable", {row, col}, last_en);
        check("scr_moves_at_fire", moves_left, N - fire_cyc.size());
        fire_cyc.push_back(j);
        fire_mv.push_back(((col != 0) ? 4 : 0) + onehot_idx(row | col));
      end
      if (scramble_done) begin
        check("scr_busy_in_done", busy, 1);
        done_cyc = j;
        break;
      end
      last_en = {row, col};
    end
    check("scr_done_seen", done_cyc >= 0, 1);
    check("scr_inj", inj, 10);
    check("scr_nfires", fire_cyc.size(), N);
    check("scr_min_latency", (done_cyc + 1) >= (N * (3 + G) + 1), 1);
    for (int i = 1; i < fire_mv.size(); i++)
      if (fire_mv[i] == fire_mv[i-1]) check("scr_repeat", fire_mv[i], 32'hFFFF);
    // Move-level model over the recorded LFSR stream
    p = 0;
    prev = 4'hF;
    for (int i = 0; i < N; i++) begin
      c = p;
      while (c < JMAX - 1 && {1'b0, hist[c][2:0]} == prev) c++;
      if (i < fire_cyc.size()) begin
        check("mdl_fire_cyc", fire_cyc[i], c + 2);
        check("mdl_move", fire_mv[i], hist[c][2:0]);
      end
      prev = {1'b0, hist[c][2:0]};
      p = c + 3 + G;
    end
    check("mdl_done_cyc", done_cyc, p);
    tick();
    check("post_busy", busy, 0);
    check("post_done", scramble_done, 0);
    check("post_moves", moves_left, 0);

    // Abort in SETUP of move 5
    scramble_start = 1'b1;
    tick();
    scramble_start = 1'b0;
    nf = 0;
    hit = 1'b0;
    for (int j = 0; j < 300; j++) begin
      tick();
      if (fire) nf++;
      if (nf == 4 && !fire && (row | col) != 0) begin
        hit = 1'b1;
        check("abort_moves_before", moves_left, N - 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        break;
      end
    end
    check("abort_reached", hit, 1);
    check("abort_busy", busy, 0);
    check("abort_moves", moves_left, 0);
    check("abort_fire", fire, 0);
    check("abort_en", {row, col}, 0);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    bad_evt = 1'b0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (fire || scramble_done) bad_evt = 1'b1;
    end
    check("abort_quiet", bad_evt, 0);

    // Async reset in the middle of a FIRE cycle
    scramble_start = 1'b1;
    tick();
    scramble_start = 1'b0;
    hit = 1'b0;
    for (int j = 0; j < 50; j++) begin
      tick();
      if (fire) begin
        hit = 1'b1;
        break;
      end
    end
    check("rstmid_fire_seen", hit, 1);
    #2 reset = 1'b0;
    m_lfsr = SEED;
    #1;
    check("rstmid_fire", fire, 0);
    check("rstmid_en", {row, col}, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_lfsr", dut.u_lfsr.out, SEED);
    #1 reset = 1'b1;
    #1;
    check("rstrel_state", 32'(dut.state_q), 32'(IDLE));
    check("rstrel_lfsr", dut.u_lfsr.out, SEED);
    tick();
    check("rstrel_lfsr_step", dut.u_lfsr.out, m_lfsr);
    check("rstrel_busy", busy, 0);

    // Start and abort together in IDLE: start wins
    scramble_start = 1'b1; abort = 1'b1;
    tick();
    scramble_start = 1'b0; abort = 1'b0;
    check("startabort_busy", busy, 1);
    check("startabort_moves", moves_left, N);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("startabort_cancel", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scramble_sequencer.md
Name: scramble_sequencer

Overview:
- Move controller for the 4x4 toggle-cell grid.
- Owns the row/col one-hot enables and the fire strobe that drive all 16 cell instances.
- Arbitrates between two sources:
  - user moves (switch selection plus debounced, edge-detected fire);
  - an internal LFSR-driven scrambler that applies NUM_MOVES random legal moves, then hands control back to the user.

Parameters:
- NUM_MOVES, 16, number of random moves per scramble (1..255).
- GAP_CYCLES, 4, idle cycles after each scramble fire before the next pick (>=1).
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- user_row_column  in  4  one-hot user selection (already error-checked upstream).
- user_nRow  in  1  0 = row move, 1 = column move.
- user_error  in  1  selection invalid (not one-hot).
- user_fire  in  1  single-cycle fire pulse (posedge-detected).
- scramble_start  in  1  single-cycle request to begin scrambling.
- abort  in  1  cancel an in-progress scramble.
- row  out  4  one-hot row enable to cells.
- col  out  4  one-hot column enable to cells.
- fire  out  1  single-cycle fire strobe to cells.
- busy  out  1  high while scrambling (states other than IDLE).
- scramble_done  out  1  one-cycle pulse when the scramble completes normally.
- moves_left  out  8  remaining scramble moves.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; row=col=0; fire=0; busy=0; scramble_done=0; moves_left=0; prev_move=4'hF (invalid); lfsr=LFSR_SEED.
- LFSR:
  - 16-bit Galois, taps 16,14,13,11.
  - Advances every clk regardless of state, so the scramble seed depends on press timing.
  - Never reaches zero.
- All outputs are registered.
- IDLE (user pass-through, 1-cycle latency):
  - If user_error: row=col=0 and fire=0.
  - Else if user_nRow=0: row=user_row_column, col=0.
  - Else: col=user_row_column, row=0.
  - fire = registered user_fire, gated by !user_error and a nonzero selection.
  - Result: the selection and fire appear on the same cycle, so cells see stable enables when fire is high.
  - scramble_start in IDLE → PICK; moves_left<=NUM_MOVES; busy=1 from the next cycle. A user_fire on that same cycle is dropped.
- PICK:
  - Candidate move m = lfsr[2:0]: bit2 = nRow, bits1:0 = index.
  - If m == prev_move: stay in PICK (the LFSR has advanced). This prevents immediately undoing the previous move.
  - Else: latch m into prev_move and go to SETUP.
  - row=col=0, fire=0.
- SETUP (1 cycle): drive the one-hot row or col decoded from m; fire=0.
- FIRE (1 cycle):
  - Hold the same row/col; fire=1.
  - moves_left decrements by 1 at the end of this cycle.
- GAP:
  - row=col=0, fire=0 for GAP_CYCLES cycles (internal counter).
  - Then: if moves_left==0 → DONE, else → PICK.
- DONE (1 cycle): scramble_done=1; prev_move<=4'hF; → IDLE.
- User inputs while busy: user_fire and user_* are ignored; no queuing.
- scramble_start while busy: ignored.
- abort in any non-IDLE state:
  - Next state is IDLE; moves_left<=0; no scramble_done pulse.
  - If abort arrives during SETUP, FIRE is suppressed.
  - If abort coincides with FIRE, that fire is still issued (already registered), then IDLE.
- abort and scramble_start in the same cycle in IDLE: start wins.
- Per-move latency: PICK (>=1) + SETUP 1 + FIRE 1 + GAP_CYCLES.
  - Minimum total = NUM_MOVES*(3+GAP_CYCLES)+1 cycles from the start pulse to scramble_done.
- Invariant: row and col are never both nonzero; at most one bit is set across the 8 enable outputs.

Decomposition:
- Shared package scramble_pkg:
  - state enum (IDLE, PICK, SETUP, FIRE, GAP, DONE);
  - MOVE_NONE = 4'hF;
  - LFSR tap constant.
- One sub-module: lfsr16 (clk, reset, out[15:0]; free-running; seed parameter).

Test Plan:
- Reset release, then user_nRow=0, user_row_column=4'b0100, user_fire pulse → next cycle row=4'b0100, col=0, fire=1 for exactly 1 cycle; busy=0.
- user_error=1 with user_fire pulse → row=col=0, fire stays 0.
- scramble_start with NUM_MOVES=16, GAP_CYCLES=4, both held for the whole scramble:
  - exactly 16 fire pulses, each with exactly one enable bit set and stable the cycle before the pulse;
  - no two consecutive moves identical;
  - scramble_done pulse at >=113 cycles after start;
  - busy falls with DONE → IDLE;
  - 10 user_fire pulses injected during the scramble produce no extra fires.
- abort asserted during the SETUP of move 5 → no 5th fire; IDLE next cycle; moves_left=0; scramble_done never pulses.
- reset driven low mid-FIRE (asynchronous, between edges) → fire, row, col, busy drop to 0 immediately; after release, state is IDLE and the LFSR equals 16'hACE1.
- Simultaneous scramble_start and abort in IDLE → scramble begins (busy=1, moves_left=16).
